multi_phase_signal_controller: RTL
==================================

Name: multi_phase_signal_controller

Overview:
- Parametrised successor to the two-road semaphore controller: serves NUM_ROADS approaches round-robin (GREEN→YELLOW→ALL_RED per road).
- Adds latched pedestrian requests served as an exclusive all-walk phase, plus a night flash mode.
- Per-road green times and shared yellow/all-red/walk times are runtime-programmable through a word-wide config port.
- Sits between the config/input logic and the lamp drivers; advanced by a 1 Hz tick enable in the single clock domain.

Parameters:
- NUM_ROADS, 2, number of approaches (2..4).
- TIME_W, 7, width of every time register and counter (seconds).
- DEF_GREEN, 30, reset value of every green register.
- DEF_YELLOW, 4, reset value of yellow register.
- DEF_ALLRED, 2, reset value of all-red register (also pedestrian clearance).
- DEF_WALK, 10, reset value of walk register.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-cycle 1 Hz enable pulse.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  3  0..NUM_ROADS-1 green[i]; NUM_ROADS yellow; NUM_ROADS+1 all_red; NUM_ROADS+2 walk; others ignored.
- cfg_data  in  TIME_W  value to write.
- ped_req  in  NUM_ROADS  pedestrian push-buttons, level or pulse.
- flash_mode  in  1  night flash request.
- road_lights  out  3*NUM_ROADS  per road {red,yellow,green} one-hot: 100 red, 010 yellow, 001 green, 000 dark.
- ped_lights  out  2*NUM_ROADS  per crossing: 01 DONT_WALK, 10 WALK, 00 off.
- time_remaining  out  TIME_W  seconds left in current phase.
- state_flag  out  3  0 GREEN, 1 YELLOW, 2 ALL_RED, 3 PED_WALK, 4 PED_CLEAR, 5 FLASH.
- active_road  out  clog2(NUM_ROADS)  road owning current GREEN/YELLOW/ALL_RED.

Behaviour:
- Reset:
  - Config registers return to their defaults; ped_pending=0; state ALL_RED; active_road=NUM_ROADS-1 (next green is road 0).
  - time_remaining=DEF_ALLRED; all roads 100; all peds 01.
  - Reset wins over tick and cfg_we in the same cycle; mid-phase reset aborts immediately.
- Timer:
  - On phase entry, time_remaining loads that phase's register.
  - Each tick decrements it by 1.
  - A tick with time_remaining==1 ends the phase: the next state is entered and the counter reloaded in that same cycle. Every phase therefore lasts exactly T ticks.
  - No decrement without tick.
- Config:
  - A written value of 0 is stored as 1.
  - New values apply at the next load only; the running phase is unaffected.
  - A write in the same cycle as a load of that register loads the old value.
- Transitions at phase end:
  - GREEN→YELLOW (same road); YELLOW→ALL_RED.
  - ALL_RED→FLASH if flash_mode=1 (highest priority).
  - Otherwise ALL_RED→PED_WALK if ped_pending≠0.
  - Otherwise ALL_RED→GREEN of (active_road+1) mod NUM_ROADS.
  - PED_WALK (walk time)→PED_CLEAR (all_red time)→GREEN of next road.
- Outputs per state:
  - GREEN/YELLOW: active road 001/010, others 100, all peds 01.
  - ALL_RED, PED_CLEAR: all roads 100, peds 01.
  - PED_WALK: all roads 100, all peds 10.
- Pedestrian requests:
  - ped_pending[i] sets on any cycle ped_req[i]=1, except during PED_WALK (requests there are ignored).
  - All of ped_pending clears on entering PED_WALK.
- Flash mode:
  - flash_mode is only honoured at the end of ALL_RED; no mid-green abort.
  - In FLASH: time_remaining=0; peds 00; all roads alternate 010/000, toggling on each tick and starting at 010 on entry.
  - When flash_mode=0 is sampled on a tick, the controller enters ALL_RED with active_road=NUM_ROADS-1, so road 0 is next.
  - ped_pending is held through FLASH.
- Safety invariant: never more than one road non-red outside FLASH.

Decomposition:
- Shared package holds:
  - state enum and state_flag codes;
  - lamp encodings (RED/YELLOW/GREEN/DARK, WALK/DONT_WALK/OFF);
  - config address offset constants.
- One sub-module, signal_phase_timer: load, decrement on tick, expire pulse, and clamp-to-1 on load value. The FSM, config bank and output decode stay in the top.

Test Plan:
- NUM_ROADS=2, defaults, tick every 4 clocks:
  - after reset, 2 ticks of ALL_RED;
  - then road0 001 for 30 ticks (time_remaining 30→1), 010 for 4, 100s for 2;
  - then road1 001;
  - active_road toggles 0→1→0.
- Write cfg_addr=1 data=5 during road1 GREEN → current green finishes 30; the following road1 green lasts 5. Write data=0 → phase lasts 1 tick.
- Pulse ped_req[0] during road0 GREEN → after road0 ALL_RED:
  - PED_WALK 10 ticks with all peds 10;
  - PED_CLEAR 2 ticks;
  - then road1 GREEN;
  - ped_req pulsed during PED_WALK produces no second walk.
- Assert flash_mode mid road0 GREEN → green/yellow/all-red complete, then FLASH: roads 010/000 alternating per tick, peds 00. Deassert → ALL_RED 2 ticks, then road0 GREEN.
- Assert reset with tick high mid-YELLOW → next cycle state_flag=2, time_remaining=2, all red, cfg registers back at defaults.
- NUM_ROADS=4 → rotation 0→1→2→3→0; assertion that at most one road is non-red at every cycle outside FLASH.

Source files
------------

// File: rtl/multi_phase_signal_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : multi_phase_signal_controller_pkg
// Brief  : Phase codes, lamp encodings and config address offsets.
// Rev    : 1.0
// ============================================================================
package multi_phase_signal_controller_pkg;

    typedef enum logic [2:0] {
        ST_GREEN     = 3'd0,
        ST_YELLOW    = 3'd1,
        ST_ALL_RED   = 3'd2,
        ST_PED_WALK  = 3'd3,
        ST_PED_CLEAR = 3'd4,
        ST_FLASH     = 3'd5
    } phase_e;

    localparam logic [2:0] c_lamp_red    = 3'b100;
    localparam logic [2:0] c_lamp_yellow = 3'b010;
    localparam logic [2:0] c_lamp_green  = 3'b001;
    localparam logic [2:0] c_lamp_dark   = 3'b000;

    localparam logic [1:0] c_ped_walk      = 2'b10;
    localparam logic [1:0] c_ped_dont_walk = 2'b01;
    localparam logic [1:0] c_ped_off       = 2'b00;

    // Shared time registers sit directly above the per-road green registers.
    localparam int C_CFG_OFS_YELLOW = 0;
    localparam int C_CFG_OFS_ALLRED = 1;
    localparam int C_CFG_OFS_WALK   = 2;

endpackage
`default_nettype wire

// File: rtl/multi_phase_signal_controller_if.sv
`default_nettype none
// ============================================================================
// Module : multi_phase_signal_controller_if
// Brief  : Tick/config/request inputs and lamp/status outputs of the controller.
// Rev    : 1.0
// ============================================================================
interface multi_phase_signal_controller_if #(
    parameter int NUM_ROADS = 2,
    parameter int TIME_W    = 7
);
    localparam int AR_W = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1;

    logic                   tick_i;
    logic                   cfg_we_i;
    logic [2:0]             cfg_addr_i;
    logic [TIME_W-1:0]      cfg_data_i;
    logic [NUM_ROADS-1:0]   ped_req_i;
    logic                   flash_mode_i;
    logic [3*NUM_ROADS-1:0] road_lights_o;
    logic [2*NUM_ROADS-1:0] ped_lights_o;
    logic [TIME_W-1:0]      time_remaining_o;
    logic [2:0]             state_flag_o;
    logic [AR_W-1:0]        active_road_o;

    modport master (
        output tick_i, cfg_we_i, cfg_addr_i, cfg_data_i, ped_req_i, flash_mode_i,
        input  road_lights_o, ped_lights_o, time_remaining_o, state_flag_o, active_road_o
    );

    modport slave (
        input  tick_i, cfg_we_i, cfg_addr_i, cfg_data_i, ped_req_i, flash_mode_i,
        output road_lights_o, ped_lights_o, time_remaining_o, state_flag_o, active_road_o
    );
endinterface
`default_nettype wire

// File: rtl/multi_phase_signal_controller_timer.sv
`default_nettype none
// ============================================================================
// Module : signal_phase_timer
// Brief  : Phase countdown: load (0 clamps to 1), decrement on tick, expire pulse.
// Rev    : 1.0
// ============================================================================
module signal_phase_timer #(
    parameter int                TIME_W    = 7,
    parameter logic [TIME_W-1:0] RESET_VAL = 2
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              tick_i,
    input  wire logic              load_i,
    input  wire logic              clear_i,
    input  wire logic [TIME_W-1:0] load_val_i,
    output logic      [TIME_W-1:0] count_o,
    output logic                   expire_o
);
    logic [TIME_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = (load_val_i == '0) ? TIME_W'(1) : load_val_i;
        end else if (tick_i && (count_q > TIME_W'(1))) begin
            count_d = count_q - TIME_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    // A parked count of 0 (flash) can never expire.
    assign expire_o = tick_i && (count_q == TIME_W'(1));
    assign count_o  = count_q;
endmodule
`default_nettype wire

// File: rtl/multi_phase_signal_controller.sv
`default_nettype none
// ============================================================================
// Module : multi_phase_signal_controller
// Brief  : Round-robin multi-road signal FSM with all-walk and night flash.
// Rev    : 1.0
// ============================================================================
module multi_phase_signal_controller #(
    parameter int NUM_ROADS  = 2,
    parameter int TIME_W     = 7,
    parameter int DEF_GREEN  = 30,
    parameter int DEF_YELLOW = 4,
    parameter int DEF_ALLRED = 2,
    parameter int DEF_WALK   = 10
) (
    input wire logic clock,
    input wire logic reset,
    multi_phase_signal_controller_if.slave bus
);
    import multi_phase_signal_controller_pkg::*;

    localparam int              AR_W          = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1;
    localparam logic [AR_W-1:0] c_last_road   = AR_W'(NUM_ROADS - 1);
    localparam logic [2:0]      c_addr_yellow = 3'(NUM_ROADS + C_CFG_OFS_YELLOW);
    localparam logic [2:0]      c_addr_allred = 3'(NUM_ROADS + C_CFG_OFS_ALLRED);
    localparam logic [2:0]      c_addr_walk   = 3'(NUM_ROADS + C_CFG_OFS_WALK);

    // ---------------- configuration bank ----------------
    logic [TIME_W-1:0] green_q [NUM_ROADS];
    logic [TIME_W-1:0] yellow_q, allred_q, walk_q;
    logic [TIME_W-1:0] w_cfg_val;

    assign w_cfg_val = (bus.cfg_data_i == '0) ? TIME_W'(1) : bus.cfg_data_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ROADS; i++) green_q[i] <= TIME_W'(DEF_GREEN);
            yellow_q <= TIME_W'(DEF_YELLOW);
            allred_q <= TIME_W'(DEF_ALLRED);
            walk_q   <= TIME_W'(DEF_WALK);
        end else if (bus.cfg_we_i) begin
            for (int i = 0; i < NUM_ROADS; i++) begin
                if (bus.cfg_addr_i == 3'(i)) green_q[i] <= w_cfg_val;
            end
            if (bus.cfg_addr_i == c_addr_yellow) yellow_q <= w_cfg_val;
            if (bus.cfg_addr_i == c_addr_allred) allred_q <= w_cfg_val;
            if (bus.cfg_addr_i == c_addr_walk)   walk_q   <= w_cfg_val;
        end
    end

    // ---------------- phase timer ----------------
    logic              w_load, w_clear, w_expire;
    logic [TIME_W-1:0] w_load_val, w_count;

    signal_phase_timer #(
        .TIME_W    (TIME_W),
        .RESET_VAL (TIME_W'(DEF_ALLRED))
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .tick_i     (bus.tick_i),
        .load_i     (w_load),
        .clear_i    (w_clear),
        .load_val_i (w_load_val),
        .count_o    (w_count),
        .expire_o   (w_expire)
    );

    // ---------------- FSM: state register ----------------
    phase_e               state_q, state_d;
    logic [AR_W-1:0]      active_road_q, active_road_d;
    logic [NUM_ROADS-1:0] ped_pending_q, ped_pending_d;
    logic                 flash_on_q, flash_on_d;
    logic [AR_W-1:0]      w_next_road;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_ALL_RED;
            active_road_q <= c_last_road;
            ped_pending_q <= '0;
            flash_on_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_road_q <= active_road_d;
            ped_pending_q <= ped_pending_d;
            flash_on_q    <= flash_on_d;
        end
    end

    assign w_next_road = (active_road_q == c_last_road) ? '0 : active_road_q + AR_W'(1);

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d       = state_q;
        active_road_d = active_road_q;
        ped_pending_d = ped_pending_q;
        flash_on_d    = flash_on_q;
        w_load        = 1'b0;
        w_clear       = 1'b0;
        w_load_val    = allred_q;

        if (state_q != ST_PED_WALK) ped_pending_d = ped_pending_q | bus.ped_req_i;

        case (state_q)
            ST_GREEN: if (w_expire) begin
                state_d    = ST_YELLOW;
                w_load     = 1'b1;
                w_load_val = yellow_q;
            end
            ST_YELLOW: if (w_expire) begin
                state_d = ST_ALL_RED;
                w_load  = 1'b1;
            end
            ST_ALL_RED: if (w_expire) begin
                if (bus.flash_mode_i) begin
                    state_d    = ST_FLASH;
                    w_clear    = 1'b1;
                    flash_on_d = 1'b1;
                end else if (|ped_pending_q) begin
                    state_d       = ST_PED_WALK;
                    w_load        = 1'b1;
                    w_load_val    = walk_q;
                    ped_pending_d = '0;
                end else begin
                    state_d       = ST_GREEN;
                    active_road_d = w_next_road;
                    w_load        = 1'b1;
                    w_load_val    = green_q[w_next_road];
                end
            end
            ST_PED_WALK: if (w_expire) begin
                state_d = ST_PED_CLEAR;
                w_load  = 1'b1;
            end
            ST_PED_CLEAR: if (w_expire) begin
                state_d       = ST_GREEN;
                active_road_d = w_next_road;
                w_load        = 1'b1;
                w_load_val    = green_q[w_next_road];
            end
            ST_FLASH: if (bus.tick_i) begin
                if (!bus.flash_mode_i) begin
                    state_d       = ST_ALL_RED;
                    active_road_d = c_last_road;
                    w_load        = 1'b1;
                end else begin
                    flash_on_d = ~flash_on_q;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                w_load  = 1'b1;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.road_lights_o    = '0;
        bus.ped_lights_o     = '0;
        bus.time_remaining_o = w_count;
        bus.state_flag_o     = state_q;
        bus.active_road_o    = active_road_q;
        for (int r = 0; r < NUM_ROADS; r++) begin
            bus.road_lights_o[3*r +: 3] = c_lamp_red;
            bus.ped_lights_o[2*r +: 2]  = c_ped_dont_walk;
            case (state_q)
                ST_GREEN:    if (active_road_q == AR_W'(r)) bus.road_lights_o[3*r +: 3] = c_lamp_green;
                ST_YELLOW:   if (active_road_q == AR_W'(r)) bus.road_lights_o[3*r +: 3] = c_lamp_yellow;
                ST_PED_WALK: bus.ped_lights_o[2*r +: 2] = c_ped_walk;
                ST_FLASH: begin
                    bus.road_lights_o[3*r +: 3] = flash_on_q ? c_lamp_yellow : c_lamp_dark;
                    bus.ped_lights_o[2*r +: 2]  = c_ped_off;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
